// File: rtl/memory_access_stage.sv
// RV32I MEM stage: data-memory req/ack handshake, store byte lanes, load extension and MEM/WB register.
// Defining MISALIGN_TRAP_EN enables the misaligned-access trap; otherwise offsets are truncated.
module memory_access_stage #(
    parameter int DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ex_valid,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [2:0]           funct3,
    input  logic [1:0]           mem_to_reg,
    input  logic                 reg_write,
    input  logic [4:0]           rd_addr,
    input  logic [DataWidth-1:0] alu_out,
    input  logic [DataWidth-1:0] store_data,
    input  logic [DataWidth-1:0] next_sel_address,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [DataWidth-1:0] dmem_addr,
    output logic [DataWidth-1:0] dmem_wdata,
    output logic [3:0]           dmem_wmask,
    input  logic                 dmem_ack,
    input  logic [DataWidth-1:0] dmem_rdata,
    output logic                 stall,
    output logic                 misalign,
    output logic                 wb_valid,
    output logic                 wb_reg_write,
    output logic [1:0]           wb_mem_to_reg,
    output logic [4:0]           wb_rd_addr,
    output logic [DataWidth-1:0] wb_alu_out,
    output logic [DataWidth-1:0] wb_data_mem_out,
    output logic [DataWidth-1:0] wb_next_sel_address
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic                 wb_valid_q, wb_valid_d;
    logic                 wb_reg_write_q, wb_reg_write_d;
    logic [1:0]           wb_mem_to_reg_q, wb_mem_to_reg_d;
    logic [4:0]           wb_rd_addr_q, wb_rd_addr_d;
    logic [DataWidth-1:0] wb_alu_out_q, wb_alu_out_d;
    logic [DataWidth-1:0] wb_data_mem_out_q, wb_data_mem_out_d;
    logic [DataWidth-1:0] wb_next_sel_address_q, wb_next_sel_address_d;

    logic                 mem_op;
    logic                 is_store;
    logic                 in_idle;
    logic                 trap;
    logic                 issue;
    logic                 req;
    logic                 complete;
    logic                 wb_load;
    logic [1:0]           off;
    logic [DataWidth-1:0] load_data;

    function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] o);
        case (size)
            2'b00:   store_mask = 4'b0001 << o;
            2'b01:   store_mask = 4'b0011 << {o[1], 1'b0};
            default: store_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_format(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'b00:   store_format = {4{data[7:0]}};
            2'b01:   store_format = {2{data[15:0]}};
            default: store_format = data;
        endcase
    endfunction

    // Halfword lane selection uses off[1] only, so a truncated offset falls out naturally.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] o,
                                                input logic [31:0] rdata);
        logic [31:0]        byte_sh;
        logic [31:0]        half_sh;
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        byte_sh = rdata >> {o, 3'b000};
        half_sh = rdata >> {o[1], 4'b0000};
        byte_s  = byte_sh[7:0];
        half_s  = half_sh[15:0];
        case (f3)
            3'b000:  load_extend = 32'(byte_s);
            3'b001:  load_extend = 32'(half_s);
            3'b100:  load_extend = {24'd0, byte_sh[7:0]};
            3'b101:  load_extend = {16'd0, half_sh[15:0]};
            default: load_extend = rdata;
        endcase
    endfunction

`ifdef MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] o);
        case (size)
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = o[0];
            default: is_misaligned = (o != 2'b00);
        endcase
    endfunction
`endif

    assign off      = alu_out[1:0];
    assign mem_op   = ex_valid & (mem_read | mem_write);
    assign is_store = mem_write & ~mem_read;
    assign in_idle  = (state_q == IDLE);

`ifdef MISALIGN_TRAP_EN
    assign trap = in_idle & mem_op & is_misaligned(funct3[1:0], off);
`else
    assign trap = 1'b0;
`endif

    // In WAIT the upstream holds its inputs, so the request fields stay stable combinationally.
    assign issue    = in_idle & mem_op & ~trap;
    assign req      = issue | (state_q == WAIT);
    assign complete = req & dmem_ack;
    assign wb_load  = (in_idle & ~mem_op) | trap | complete;

    assign dmem_req   = req;
    assign dmem_we    = req & is_store;
    assign dmem_addr  = req ? {alu_out[DataWidth-1:2], 2'b00} : '0;
    assign dmem_wmask = (req & is_store) ? store_mask(funct3[1:0], off) : 4'b0000;
    assign dmem_wdata = (req & is_store) ? store_format(funct3[1:0], store_data) : '0;
    assign stall      = req & ~dmem_ack;
    assign misalign   = trap;

    assign load_data = load_extend(funct3, off, dmem_rdata);

    always_comb begin
        state_d               = state_q;
        wb_valid_d            = 1'b0;
        wb_reg_write_d        = wb_reg_write_q;
        wb_mem_to_reg_d       = wb_mem_to_reg_q;
        wb_rd_addr_d          = wb_rd_addr_q;
        wb_alu_out_d          = wb_alu_out_q;
        wb_data_mem_out_d     = wb_data_mem_out_q;
        wb_next_sel_address_d = wb_next_sel_address_q;

        if (in_idle) begin
            if (issue && !dmem_ack) begin
                state_d = WAIT;
            end
        end else if (dmem_ack) begin
            state_d = IDLE;
        end

        if (wb_load) begin
            wb_valid_d            = ex_valid | (state_q == WAIT);
            wb_reg_write_d        = reg_write & ~trap;
            wb_mem_to_reg_d       = mem_to_reg;
            wb_rd_addr_d          = rd_addr;
            wb_alu_out_d          = alu_out;
            wb_next_sel_address_d = next_sel_address;
            wb_data_mem_out_d     = (mem_op & mem_read & ~trap) ? load_data : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q               <= IDLE;
            wb_valid_q            <= 1'b0;
            wb_reg_write_q        <= 1'b0;
            wb_mem_to_reg_q       <= 2'b00;
            wb_rd_addr_q          <= 5'd0;
            wb_alu_out_q          <= '0;
            wb_data_mem_out_q     <= '0;
            wb_next_sel_address_q <= '0;
        end else begin
            state_q               <= state_d;
            wb_valid_q            <= wb_valid_d;
            wb_reg_write_q        <= wb_reg_write_d;
            wb_mem_to_reg_q       <= wb_mem_to_reg_d;
            wb_rd_addr_q          <= wb_rd_addr_d;
            wb_alu_out_q          <= wb_alu_out_d;
            wb_data_mem_out_q     <= wb_data_mem_out_d;
            wb_next_sel_address_q <= wb_next_sel_address_d;
        end
    end

    assign wb_valid            = wb_valid_q;
    assign wb_reg_write        = wb_reg_write_q;
    assign wb_mem_to_reg       = wb_mem_to_reg_q;
    assign wb_rd_addr          = wb_rd_addr_q;
    assign wb_alu_out          = wb_alu_out_q;
    assign wb_data_mem_out     = wb_data_mem_out_q;
    assign wb_next_sel_address = wb_next_sel_address_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: scoreboard of expected MEM/WB results.
// Misalign checks follow MISALIGN_TRAP_EN when the macro is defined for the build.
module tb_memory_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, mem_read, mem_write, reg_write;
    logic [2:0]  funct3;
    logic [1:0]  mem_to_reg;
    logic [4:0]  rd_addr;
    logic [31:0] alu_out, store_data, next_sel_address;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wmask;
    logic        stall, misalign;
    logic        wb_valid, wb_reg_write;
    logic [1:0]  wb_mem_to_reg;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_alu_out, wb_data_mem_out, wb_next_sel_address;

    typedef struct {
        logic        reg_write;
        logic [1:0]  m2r;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] data;
        logic [31:0] nsa;
    } wb_exp_t;

    typedef struct {
        logic        req;
        logic        we;
        logic        mis;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          stall_cnt;
        int          bubble_bad;
        int          held_bad;
    } obs_t;

    wb_exp_t sb[$];
    int      checks = 0;
    int      errors = 0;
    int      op_id = 0;

    memory_access_stage #(.DataWidth(32)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .rd_addr(rd_addr),
        .alu_out(alu_out), .store_data(store_data), .next_sel_address(next_sel_address),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wmask(dmem_wmask), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall(stall),
        .misalign(misalign), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_rd_addr(wb_rd_addr), .wb_alu_out(wb_alu_out),
        .wb_data_mem_out(wb_data_mem_out), .wb_next_sel_address(wb_next_sel_address)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] o, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        case (o)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = o[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  ref_load = {{24{b[7]}}, b};
            3'b001:  ref_load = {{16{h[15]}}, h};
            3'b100:  ref_load = {24'h0, b};
            3'b101:  ref_load = {16'h0, h};
            default: ref_load = rd;
        endcase
    endfunction

    task automatic idle_inputs;
        ex_valid = 0; mem_read = 0; mem_write = 0; reg_write = 0; funct3 = 0; mem_to_reg = 0;
        rd_addr = 0; alu_out = 0; store_data = 0; next_sel_address = 0; dmem_ack = 0; dmem_rdata = 0;
    endtask

    // Drives one memory op, acks after 'waits' cycles, ends at the negedge after the wb load.
    task automatic run_op(input logic rd_, input logic wr_, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] rdata, input logic [31:0] exp_data,
                          input int waits, output obs_t o);
        wb_exp_t e;
        op_id++;
        ex_valid = 1; mem_read = rd_; mem_write = wr_; funct3 = f3; alu_out = addr; store_data = sdata;
        mem_to_reg = 2'b01; reg_write = rd_; rd_addr = op_id[4:0];
        next_sel_address = 32'h1000 + (op_id << 2); dmem_rdata = rdata; dmem_ack = (waits == 0);
        e.reg_write = rd_; e.m2r = 2'b01; e.rd = op_id[4:0]; e.alu = addr; e.data = exp_data;
        e.nsa = 32'h1000 + (op_id << 2);
        sb.push_back(e);
        #1;
        o.req = dmem_req; o.we = dmem_we; o.mis = misalign; o.addr = dmem_addr;
        o.wdata = dmem_wdata; o.wmask = dmem_wmask;
        o.stall_cnt = 0; o.bubble_bad = 0; o.held_bad = 0;
        for (int i = 0; i < waits; i++) begin
            if (stall) o.stall_cnt++;
            @(posedge clk); @(negedge clk);
            if (wb_valid !== 1'b0) o.bubble_bad++;
            if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask} !== {1'b1, o.we, o.addr, o.wdata, o.wmask})
                o.held_bad++;
            if (i == waits - 1) dmem_ack = 1;
            #1;
        end
        if (stall) o.stall_cnt++;
        @(posedge clk); @(negedge clk);
        dmem_ack = 0;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 0;
        #1;
        checks++;
        if ({stall, dmem_req, dmem_we, misalign, dmem_wmask} !== 8'h00) begin
            errors++; $display("FAIL reset_ctrl: got %b, want 00000000", {stall, dmem_req, dmem_we, misalign, dmem_wmask});
        end
        checks++;
        if ({dmem_addr, dmem_wdata} !== 64'h0) begin
            errors++; $display("FAIL reset_dmem: got addr=%h wdata=%h, want 0", dmem_addr, dmem_wdata);
        end
        checks++;
        if ({wb_valid, wb_reg_write, wb_mem_to_reg, wb_rd_addr, wb_alu_out, wb_data_mem_out, wb_next_sel_address} !== '0) begin
            errors++; $display("FAIL reset_wb: got v=%b rw=%b m2r=%b rd=%0d alu=%h data=%h nsa=%h, want all 0",
                              wb_valid, wb_reg_write, wb_mem_to_reg, wb_rd_addr, wb_alu_out, wb_data_mem_out, wb_next_sel_address);
        end
    endtask

    task automatic test_alu_op;
        wb_exp_t e;
        @(negedge clk);
        ex_valid = 1; alu_out = 32'h1234; mem_to_reg = 2'b00; rd_addr = 5; reg_write = 1;
        next_sel_address = 32'h88;
        sb.push_back('{reg_write: 1'b1, m2r: 2'b00, rd: 5'd5, alu: 32'h1234, data: 32'h0, nsa: 32'h88});
        #1;
        checks++;
        if ({dmem_req, stall} !== 2'b00) begin
            errors++; $display("FAIL alu_no_req: got req=%b stall=%b, want 0 0", dmem_req, stall);
        end
        @(posedge clk); @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (wb_valid !== 1'b1 || wb_data_mem_out !== e.data) begin
            errors++; $display("FAIL alu_wb_valid: got v=%b data=%h, want 1 %h", wb_valid, wb_data_mem_out, e.data);
        end
        checks++;
        if ({wb_reg_write, wb_mem_to_reg, wb_rd_addr, wb_alu_out, wb_next_sel_address} !== {e.reg_write, e.m2r, e.rd, e.alu, e.nsa}) begin
            errors++; $display("FAIL alu_wb_fields: got rw=%b m2r=%b rd=%0d alu=%h nsa=%h, want %b %b %0d %h %h",
                              wb_reg_write, wb_mem_to_reg, wb_rd_addr, wb_alu_out, wb_next_sel_address,
                              e.reg_write, e.m2r, e.rd, e.alu, e.nsa);
        end
        idle_inputs();
        @(posedge clk); @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++; $display("FAIL alu_invalid_slot: got wb_valid=%b, want 0", wb_valid);
        end
    endtask

    task automatic test_load_wait;
        obs_t o; wb_exp_t e;
        run_op(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_FF7F, 32'hFFFF_FF80, 2, o);
        e = sb.pop_front();
        checks++;
        if (o.stall_cnt != 2 || o.bubble_bad != 0 || o.held_bad != 0) begin
            errors++; $display("FAIL lb_wait_stall: got stall_cycles=%0d bubbles_bad=%0d held_bad=%0d, want 2 0 0",
                              o.stall_cnt, o.bubble_bad, o.held_bad);
        end
        checks++;
        if ({o.req, o.we, o.wmask, o.addr} !== {1'b1, 1'b0, 4'b0000, 32'h100}) begin
            errors++; $display("FAIL lb_wait_req: got req=%b we=%b mask=%b addr=%h, want 1 0 0000 00000100", o.req, o.we, o.wmask, o.addr);
        end
        checks++;
        if (wb_valid !== 1'b1 || wb_data_mem_out !== e.data || wb_rd_addr !== e.rd || wb_next_sel_address !== e.nsa) begin
            errors++; $display("FAIL lb_wait_wb: got v=%b data=%h rd=%0d nsa=%h, want 1 %h %0d %h",
                              wb_valid, wb_data_mem_out, wb_rd_addr, wb_next_sel_address, e.data, e.rd, e.nsa);
        end
        idle_inputs();
    endtask

    task automatic test_lhu_zero_wait;
        obs_t o; wb_exp_t e;
        run_op(1, 0, 3'b101, 32'h102, 32'h0, 32'hBEEF_1234, 32'h0000_BEEF, 0, o);
        e = sb.pop_front();
        checks++;
        if (o.stall_cnt != 0 || o.req !== 1'b1 || o.addr !== 32'h100) begin
            errors++; $display("FAIL lhu_req: got stall_cycles=%0d req=%b addr=%h, want 0 1 00000100", o.stall_cnt, o.req, o.addr);
        end
        checks++;
        if (wb_valid !== 1'b1 || wb_data_mem_out !== e.data || wb_reg_write !== e.reg_write) begin
            errors++; $display("FAIL lhu_wb: got v=%b data=%h rw=%b, want 1 %h %b", wb_valid, wb_data_mem_out, wb_reg_write, e.data, e.reg_write);
        end
        idle_inputs();
    endtask

    task automatic test_store_byte;
        obs_t o; wb_exp_t e;
        run_op(0, 1, 3'b000, 32'h201, 32'hAABB_CCDD, 32'h1234_5678, 32'h0, 1, o);
        e = sb.pop_front();
        checks++;
        if ({o.we, o.wmask, o.wdata, o.addr} !== {1'b1, 4'b0010, 32'hDDDD_DDDD, 32'h200}) begin
            errors++; $display("FAIL sb_req: got we=%b mask=%b wdata=%h addr=%h, want 1 0010 dddddddd 00000200", o.we, o.wmask, o.wdata, o.addr);
        end
        checks++;
        if (o.stall_cnt != 1 || o.held_bad != 0) begin
            errors++; $display("FAIL sb_stall: got stall_cycles=%0d held_bad=%0d, want 1 0", o.stall_cnt, o.held_bad);
        end
        checks++;
        if (wb_valid !== 1'b1 || wb_data_mem_out !== e.data || wb_alu_out !== e.alu || wb_reg_write !== e.reg_write) begin
            errors++; $display("FAIL sb_wb: got v=%b data=%h alu=%h rw=%b, want 1 %h %h %b", wb_valid, wb_data_mem_out, wb_alu_out, wb_reg_write, e.data, e.alu, e.reg_write);
        end
        idle_inputs();
    endtask

    task automatic test_load_sweep;
        obs_t o; wb_exp_t e;
        logic [2:0]  f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [31:0] rdata, addr;
        logic [1:0]  o2;
        logic        skip;
        int          w;
        for (int k = 0; k < 5; k++) begin
            for (int off = 0; off < 4; off++) begin
                o2 = off[1:0];
                skip = 1'b0;
`ifdef MISALIGN_TRAP_EN
                skip = (f3s[k][1:0] == 2'b01 && o2[0]) || (f3s[k][1:0] == 2'b10 && o2 != 2'b00);
`endif
                if (!skip) begin
                    rdata = $urandom;
                    w = $urandom_range(0, 2);
                    addr = 32'h400 + (k << 4) + off;
                    run_op(1, 0, f3s[k], addr, 32'h0, rdata, ref_load(f3s[k], o2, rdata), w, o);
                    e = sb.pop_front();
                    checks++;
                    if (o.stall_cnt != w || o.addr !== {addr[31:2], 2'b00} || o.wmask !== 4'b0000) begin
                        errors++; $display("FAIL load_sweep_req f3=%b off=%0d: got stall=%0d addr=%h mask=%b, want %0d %h 0000",
                                          f3s[k], off, o.stall_cnt, o.addr, o.wmask, w, {addr[31:2], 2'b00});
                    end
                    checks++;
                    if (wb_valid !== 1'b1 || wb_data_mem_out !== e.data) begin
                        errors++; $display("FAIL load_sweep_data f3=%b off=%0d rdata=%h: got v=%b data=%h, want 1 %h",
                                          f3s[k], off, rdata, wb_valid, wb_data_mem_out, e.data);
                    end
                    idle_inputs();
                end
            end
        end
    endtask

    task automatic test_store_sweep;
        obs_t o; wb_exp_t e;
        logic [31:0] sd, addr, exp_wd;
        logic [3:0]  exp_m;
        logic [1:0]  o2;
        logic        skip;
        for (int k = 0; k < 3; k++) begin
            for (int off = 0; off < 4; off++) begin
                o2 = off[1:0];
                skip = 1'b0;
`ifdef MISALIGN_TRAP_EN
                skip = (k == 1 && o2[0]) || (k == 2 && o2 != 2'b00);
`endif
                if (!skip) begin
                    sd = $urandom;
                    addr = 32'h600 + (k << 4) + off;
                    case (k)
                        0: begin exp_m = (o2 == 0) ? 4'b0001 : (o2 == 1) ? 4'b0010 : (o2 == 2) ? 4'b0100 : 4'b1000; exp_wd = {sd[7:0], sd[7:0], sd[7:0], sd[7:0]}; end
                        1: begin exp_m = o2[1] ? 4'b1100 : 4'b0011; exp_wd = {sd[15:0], sd[15:0]}; end
                        default: begin exp_m = 4'b1111; exp_wd = sd; end
                    endcase
                    run_op(0, 1, 3'(k), addr, sd, 32'hFFFF_FFFF, 32'h0, k % 2, o);
                    e = sb.pop_front();
                    checks++;
                    if ({o.we, o.wmask, o.wdata} !== {1'b1, exp_m, exp_wd}) begin
                        errors++; $display("FAIL store_sweep k=%0d off=%0d: got we=%b mask=%b wdata=%h, want 1 %b %h",
                                          k, off, o.we, o.wmask, o.wdata, exp_m, exp_wd);
                    end
                    checks++;
                    if (wb_valid !== 1'b1 || wb_data_mem_out !== e.data) begin
                        errors++; $display("FAIL store_sweep_wb k=%0d off=%0d: got v=%b data=%h, want 1 %h", k, off, wb_valid, wb_data_mem_out, e.data);
                    end
                    idle_inputs();
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        obs_t o; wb_exp_t e;
        run_op(1, 0, 3'b010, 32'h500, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, o);
        e = sb.pop_front();
        checks++;
        if (wb_valid !== 1'b1 || wb_data_mem_out !== e.data || wb_rd_addr !== e.rd) begin
            errors++; $display("FAIL b2b_first: got v=%b data=%h rd=%0d, want 1 %h %0d", wb_valid, wb_data_mem_out, wb_rd_addr, e.data, e.rd);
        end
        run_op(0, 1, 3'b001, 32'h506, 32'h1111_ABCD, 32'h0, 32'h0, 1, o);
        e = sb.pop_front();
        checks++;
        if ({o.req, o.wmask, o.wdata, o.stall_cnt[3:0]} !== {1'b1, 4'b1100, 32'hABCD_ABCD, 4'd1} || wb_valid !== 1'b1 || wb_alu_out !== e.alu) begin
            errors++; $display("FAIL b2b_second: got req=%b mask=%b wdata=%h stall=%0d v=%b alu=%h, want 1 1100 abcdabcd 1 1 %h",
                              o.req, o.wmask, o.wdata, o.stall_cnt, wb_valid, wb_alu_out, e.alu);
        end
        run_op(1, 0, 3'b100, 32'h50A, 32'h0, 32'h00C3_0000, 32'h0000_00C3, 0, o);
        e = sb.pop_front();
        checks++;
        if (o.req !== 1'b1 || wb_valid !== 1'b1 || wb_data_mem_out !== e.data || wb_rd_addr !== e.rd) begin
            errors++; $display("FAIL b2b_third: got req=%b v=%b data=%h rd=%0d, want 1 1 %h %0d", o.req, wb_valid, wb_data_mem_out, wb_rd_addr, e.data, e.rd);
        end
        idle_inputs();
    endtask

    task automatic test_stray_ack;
        idle_inputs();
        mem_read = 1; dmem_ack = 1; dmem_rdata = 32'h5555_5555;
        #1;
        checks++;
        if ({dmem_req, stall, misalign} !== 3'b000) begin
            errors++; $display("FAIL stray_ack_req: got req=%b stall=%b mis=%b, want 0 0 0", dmem_req, stall, misalign);
        end
        @(posedge clk); @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0 || wb_data_mem_out !== 32'h0) begin
            errors++; $display("FAIL stray_ack_wb: got v=%b data=%h, want 0 00000000", wb_valid, wb_data_mem_out);
        end
        idle_inputs();
    endtask

    task automatic test_reset_in_wait;
        idle_inputs();
        ex_valid = 1; mem_read = 1; funct3 = 3'b010; alu_out = 32'h300; reg_write = 1;
        @(posedge clk); @(negedge clk);
        checks++;
        if ({dmem_req, stall, wb_valid} !== 3'b110) begin
            errors++; $display("FAIL wait_state: got req=%b stall=%b v=%b, want 1 1 0", dmem_req, stall, wb_valid);
        end
        reset = 1;
        @(posedge clk); @(negedge clk);
        reset = 0;
        idle_inputs();
        #1;
        checks++;
        if ({dmem_req, stall, wb_valid} !== 3'b000) begin
            errors++; $display("FAIL reset_in_wait: got req=%b stall=%b v=%b, want 0 0 0", dmem_req, stall, wb_valid);
        end
        dmem_ack = 1; dmem_rdata = 32'h7777_7777;
        @(posedge clk); @(negedge clk);
        checks++;
        if ({dmem_req, stall, wb_valid} !== 3'b000 || wb_data_mem_out !== 32'h0) begin
            errors++; $display("FAIL late_ack: got req=%b stall=%b v=%b data=%h, want 0 0 0 00000000", dmem_req, stall, wb_valid, wb_data_mem_out);
        end
        idle_inputs();
    endtask

    task automatic test_misalign;
`ifdef MISALIGN_TRAP_EN
        idle_inputs();
        ex_valid = 1; mem_read = 1; funct3 = 3'b010; alu_out = 32'h102; reg_write = 1; rd_addr = 9;
        #1;
        checks++;
        if ({misalign, dmem_req, stall} !== 3'b100) begin
            errors++; $display("FAIL misalign_pulse: got mis=%b req=%b stall=%b, want 1 0 0", misalign, dmem_req, stall);
        end
        @(posedge clk); @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if ({misalign, wb_valid, wb_reg_write, dmem_req} !== 4'b0100 || wb_rd_addr !== 5'd9) begin
            errors++; $display("FAIL misalign_wb: got mis=%b v=%b rw=%b req=%b rd=%0d, want 0 1 0 0 9", misalign, wb_valid, wb_reg_write, dmem_req, wb_rd_addr);
        end
`else
        obs_t o; wb_exp_t e;
        run_op(1, 0, 3'b010, 32'h102, 32'h0, 32'h3C3C_A5A5, 32'h3C3C_A5A5, 0, o);
        e = sb.pop_front();
        checks++;
        if ({o.mis, o.req, o.addr} !== {1'b0, 1'b1, 32'h100}) begin
            errors++; $display("FAIL misalign_tied: got mis=%b req=%b addr=%h, want 0 1 00000100", o.mis, o.req, o.addr);
        end
        checks++;
        if (wb_valid !== 1'b1 || wb_reg_write !== e.reg_write || wb_data_mem_out !== e.data) begin
            errors++; $display("FAIL misalign_trunc_wb: got v=%b rw=%b data=%h, want 1 %b %h", wb_valid, wb_reg_write, wb_data_mem_out, e.reg_write, e.data);
        end
        idle_inputs();
`endif
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_load_wait();
        test_lhu_zero_wait();
        test_store_byte();
        test_load_sweep();
        test_store_sweep();
        test_back_to_back();
        test_stray_ack();
        test_reset_in_wait();
        test_misalign();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

Pipeline MEM stage of the RV32I core, sitting between the execute stage and the writeback mux. It issues loads and stores to the data memory over a req/ack handshake, builds store byte masks, and sign- or zero-extends load data. It stalls the pipeline while a memory access is outstanding and registers the MEM/WB pipeline fields. Those registered fields are exactly what the writeback selector consumes: `mem_to_reg`, `alu_out`, `data_mem_out` and `next_sel_address`.

## Interface
- `DataWidth`, 32, datapath width; only 32 is supported.
- `clk` in 1: the single clock; every register updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `ex_valid` in 1: the EX/MEM slot holds a valid instruction.
- `mem_read`, `mem_write` in 1 each: load or store. Both high together is illegal and is treated as a load.
- `funct3` in 3: access size and signedness (LB/LH/LW/LBU/LHU, SB/SH/SW encodings).
- `mem_to_reg` in 2: writeback select, passed through.
- `reg_write` in 1: register-file write enable, passed through.
- `rd_addr` in 5: destination register, passed through.
- `alu_out` in DataWidth: ALU result, which is also the effective address.
- `store_data` in DataWidth: rs2 value for stores.
- `next_sel_address` in DataWidth: PC+4, passed through.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out DataWidth, `dmem_wdata` out DataWidth, `dmem_wmask` out 4: data memory request.
- `dmem_ack` in 1, `dmem_rdata` in DataWidth: data memory response.
- `stall` out 1: upstream must hold all inputs stable while this is high.
- `misalign` out 1: pulse flagging a misaligned access. Tied to 0 without the macro.
- `wb_valid`, `wb_reg_write` out 1; `wb_mem_to_reg` out 2; `wb_rd_addr` out 5; `wb_alu_out`, `wb_data_mem_out`, `wb_next_sel_address` out DataWidth: the MEM/WB register.

## Operation
- FSM states are IDLE and WAIT. A memory op is `ex_valid & (mem_read | mem_write)`.
- **IDLE, no memory op:** the MEM/WB register loads the inputs, with `wb_valid = ex_valid` and `wb_data_mem_out = 0`.
- **IDLE, memory op:**
  - `dmem_req` rises combinationally in the same cycle.
  - `dmem_we = mem_write`.
  - `dmem_addr = {alu_out[31:2], 2'b00}`.
  - If `dmem_ack` is also high, the access completes this cycle and the MEM/WB register loads.
  - Otherwise `stall` is high, the FSM moves to WAIT, and `wb_valid` is loaded with 0 (a bubble).
- **WAIT:**
  - `dmem_req` is held high, with all dmem outputs driven from the held inputs.
  - `stall = ~dmem_ack`.
  - On `dmem_ack`: the MEM/WB register loads, `wb_valid = 1`, and the FSM returns to IDLE.
  - Without `dmem_ack`: `wb_valid` stays 0.
- **Store mask and data:** byte offset `off = alu_out[1:0]`.
  - SB: mask = `4'b0001 << off`, data = the byte replicated ×4.
  - SH: mask = `4'b0011 << {off[1],1'b0}`, data = the half replicated ×2.
  - SW: mask = `4'b1111`, data = `store_data`.
  - Loads drive `dmem_wmask = 0`.
- **Load extension:** select the byte or half of `dmem_rdata` at `off`, then apply the extension:
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - LW passes the word through.
  - The result goes to `wb_data_mem_out`.
  - Stores write 0 to `wb_data_mem_out`.
- **Stray acks:** `dmem_ack` arriving in IDLE with no request is ignored.

## Timing
- Reset values:
  - FSM is IDLE.
  - `stall`, `dmem_req`, `dmem_we` and `misalign` are 0.
  - `dmem_addr`, `dmem_wdata` and `dmem_wmask` are 0.
  - All `wb_*` outputs are 0.
- Latency from instruction accept to `wb_valid`:
  - Non-memory instruction: 1 cycle.
  - Memory op with zero-wait ack: 1 cycle.
  - Memory op with N wait cycles: N+1 cycles.
- `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata` and `dmem_wmask` must not change while `dmem_req` is high and ack has not arrived.
- `stall` is combinational. It is never high in a cycle where `dmem_ack` completes the access.
- **Reset in WAIT:** the next state is IDLE and `dmem_req` drops in the following cycle. The outstanding access is abandoned, and an ack arriving after reset is ignored.
- Back-to-back memory ops are allowed: a new op can issue in IDLE the cycle after completion.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - A misaligned access raises `misalign` for one cycle and issues no `dmem_req`. An access is misaligned if it is LH/LHU/SH with `off[0] = 1`, or LW/SW with `off != 0`.
  - That cycle, MEM/WB loads with `wb_valid = 1` and `wb_reg_write = 0`.
  - The FSM stays in IDLE.
- `MISALIGN_TRAP_EN` undefined:
  - `misalign` is tied to 0.
  - Offsets are truncated: halfword access uses `off[1]` only, word access ignores `off`.

## Test plan
- ALU op, `alu_out = 0x1234`, `mem_to_reg = 00`, `rd_addr = 5` → one cycle later `wb_valid = 1`, `wb_alu_out = 0x1234`, `wb_rd_addr = 5`, and `dmem_req` never rises.
- LB at address 0x103, `dmem_rdata = 0x80FF_FF7F`, ack after 2 wait cycles → `stall` is high for 2 cycles and `wb_valid = 0` during them. Then `wb_data_mem_out = 0xFFFF_FF80` and `dmem_addr = 0x100`.
- LHU at 0x102, `rdata = 0xBEEF_1234`, zero-wait → `wb_data_mem_out = 0x0000_BEEF`, `stall` never high.
- SB at 0x201, `store_data = 0xAABB_CCDD` → `dmem_wmask = 0010`, `dmem_wdata = 0xDDDD_DDDD`, `dmem_we = 1`, `wb_data_mem_out = 0`.
- Reset asserted in WAIT, then a late ack → the next state is IDLE, and `dmem_req`, `stall` and `wb_valid` are 0. The ack produces no writeback.
- With `MISALIGN_TRAP_EN`, LW at 0x102 → `misalign` = 1 for one cycle, no `dmem_req`, `wb_reg_write = 0`.
